// File: rtl/pulse_rx_multi.sv
// Pulse-distance receiver: synchronises and debounces the raw receiver pin,
// times burst/silence durations and decodes sync, repeat and variable-length
// data frames into a right-aligned code word with its bit count.
module pulse_rx_multi #(
  parameter int SBD       = 1000,
  parameter int SSD       = 1000,
  parameter int RSD       = 500,
  parameter int BBD       = 500,
  parameter int BSD0      = 250,
  parameter int BSD1      = 500,
  parameter int MARGIN    = 100,
  parameter int MAX_WIDTH = 128,
  parameter int DEBOUNCE  = 4
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               signal_in,
  output logic [MAX_WIDTH-1:0]               code_out,
  output logic [$clog2(MAX_WIDTH+1)-1:0]     len_out,
  output logic                               new_code_out,
  output logic                               repeat_out,
  output logic [2:0]                         error_out,
  output logic                               new_error_out,
  output logic [3:0]                         state_out
);

  localparam int LW      = $clog2(MAX_WIDTH + 1);
  localparam int LONGEST = (SBD > SSD) ? SBD : SSD;
  localparam int CW      = $clog2(LONGEST + MARGIN + 2);
  localparam int DW      = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam logic [CW-1:0] SB_LO   = CW'(SBD - MARGIN);
  localparam logic [CW-1:0] SB_HI   = CW'(SBD + MARGIN);
  localparam logic [CW-1:0] SS_HI   = CW'(SSD + MARGIN);
  localparam logic [CW-1:0] BB_HI   = CW'(BBD + MARGIN);
  localparam logic [CW-1:0] END_CNT = CW'(BSD1 + MARGIN + 1);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    SYNC_BURST = 4'd1,
    SYNC_SIL   = 4'd2,
    BIT_BURST  = 4'd3,
    BIT_SIL    = 4'd4,
    REP_BURST  = 4'd5,
    ERROR      = 4'd6
  } state_t;

  state_t                state;
  logic                  sync_p0, sync_p1;
  logic                  level, level_d;
  logic [DW-1:0]         deb_cnt;
  logic [CW-1:0]         cnt;
  logic [MAX_WIDTH-1:0]  shift;
  logic [LW-1:0]         bit_cnt;
  logic                  rise, fall;

  // Duration counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    sat_inc = (&c) ? c : c + 1'b1;
  endfunction

  // True when a measured duration lies within +/-MARGIN of nominal n.
  function automatic logic in_win(input logic [CW-1:0] c, input int n);
    in_win = (c >= CW'(n - MARGIN)) && (c <= CW'(n + MARGIN));
  endfunction

  assign rise      = level & ~level_d;
  assign fall      = ~level & level_d;
  assign state_out = state;

  // Two-flop synchroniser on the asynchronous receiver pin.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= signal_in;
      sync_p1 <= sync_p0;
    end
  end

  // Glitch filter: adopt the new level only after DEBOUNCE equal samples.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      level   <= 1'b0;
      deb_cnt <= '0;
    end else if (sync_p1 != level) begin
      if (deb_cnt == DW'(DEBOUNCE - 1)) begin
        level   <= sync_p1;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  // Edge history and cycles-since-edge counter; on an edge cycle cnt equals
  // the length of the level that just ended.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      level_d <= level;
      cnt     <= (level != level_d) ? CW'(1) : sat_inc(cnt);
    end
  end

  // Frame decoder FSM with registered code, length, error and pulse outputs.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state         <= IDLE;
      shift         <= '0;
      bit_cnt       <= '0;
      code_out      <= '0;
      len_out       <= '0;
      error_out     <= '0;
      new_code_out  <= 1'b0;
      repeat_out    <= 1'b0;
      new_error_out <= 1'b0;
    end else begin
      new_code_out  <= 1'b0;
      repeat_out    <= 1'b0;
      new_error_out <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) state <= SYNC_BURST;
        end
        SYNC_BURST: begin
          if (cnt > SB_HI) begin
            state <= ERROR; error_out <= 3'd1; new_error_out <= 1'b1;
          end else if (fall) begin
            // A short burst is treated as noise and dropped without an error.
            state <= (cnt >= SB_LO) ? SYNC_SIL : IDLE;
          end
        end
        SYNC_SIL: begin
          if (rise) begin
            if (in_win(cnt, SSD)) begin
              // Accepted sync: start a fresh message and forget the old error.
              state     <= BIT_BURST;
              shift     <= '0;
              bit_cnt   <= '0;
              error_out <= '0;
            end else if (in_win(cnt, RSD)) begin
              state <= REP_BURST;
            end else begin
              state <= ERROR; error_out <= 3'd2; new_error_out <= 1'b1;
            end
          end else if (cnt > SS_HI) begin
            state <= ERROR; error_out <= 3'd2; new_error_out <= 1'b1;
          end
        end
        REP_BURST: begin
          if (cnt > BB_HI) begin
            state <= ERROR; error_out <= 3'd2; new_error_out <= 1'b1;
          end else if (fall) begin
            if (in_win(cnt, BBD)) begin
              repeat_out <= 1'b1;
              state      <= IDLE;
            end else begin
              state <= ERROR; error_out <= 3'd2; new_error_out <= 1'b1;
            end
          end
        end
        BIT_BURST: begin
          if (cnt > BB_HI) begin
            state <= ERROR; error_out <= 3'd3; new_error_out <= 1'b1;
          end else if (fall) begin
            if (in_win(cnt, BBD)) begin
              state <= BIT_SIL;
            end else begin
              state <= ERROR; error_out <= 3'd3; new_error_out <= 1'b1;
            end
          end
        end
        BIT_SIL: begin
          if (rise) begin
            if (in_win(cnt, BSD0) || in_win(cnt, BSD1)) begin
              if (bit_cnt == LW'(MAX_WIDTH)) begin
                state <= ERROR; error_out <= 3'd5; new_error_out <= 1'b1;
              end else begin
                // First bit received ends up at position len-1.
                shift   <= {shift[MAX_WIDTH-2:0], in_win(cnt, BSD1)};
                bit_cnt <= bit_cnt + 1'b1;
                state   <= BIT_BURST;
              end
            end else begin
              state <= ERROR; error_out <= 3'd4; new_error_out <= 1'b1;
            end
          end else if (cnt >= END_CNT) begin
            // Silence too long for a bit: the preceding burst terminated the message.
            if (bit_cnt != '0) begin
              code_out     <= shift;
              len_out      <= bit_cnt;
              new_code_out <= 1'b1;
              state        <= IDLE;
            end else begin
              state <= ERROR; error_out <= 3'd6; new_error_out <= 1'b1;
            end
          end
        end
        ERROR: begin
          // Wait for a long quiet line before listening for the next sync.
          if (!level && !level_d && cnt >= SS_HI) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pulse_rx_multi.md
Name: pulse_rx_multi

Overview:
- Parametrised successor to the fixed-width pulse-distance receiver.
- Decodes a sync burst, a sync silence, and then a variable-length run of bit burst/silence pairs (1..MAX_WIDTH bits).
- Adds four things: an input synchroniser with glitch filter, end-of-message detection by silence timeout with a reported length, repeat-frame detection, and latched error reporting.
- Sits between the raw receiver input pin and the command decoder.

Parameters:
- SBD, 1000: sync burst duration, in cycles.
- SSD, 1000: sync silence duration.
- RSD, 500: repeat-frame silence duration.
- BBD, 500: bit burst duration.
- BSD0, 250: bit silence duration for a 0.
- BSD1, 500: bit silence duration for a 1.
- MARGIN, 100: +/- tolerance applied to every duration.
- MAX_WIDTH, 128: maximum message bits; width of code_out.
- DEBOUNCE, 4: cycles the input must be stable before the filtered level changes.

Ports:
- clk_in, input, 1: system clock.
- rst_in, input, 1: synchronous reset, active-low.
- signal_in, input, 1: raw asynchronous receiver level (1 = burst).
- code_out, output, MAX_WIDTH: last good code, right-aligned.
- len_out, output, $clog2(MAX_WIDTH+1): bit count of code_out.
- new_code_out, output, 1: one-cycle pulse when code_out/len_out update.
- repeat_out, output, 1: one-cycle pulse on a valid repeat frame.
- error_out, output, 3: latched error code.
- new_error_out, output, 1: one-cycle pulse when error_out is written.
- state_out, output, 4: current FSM state.

Behaviour:
- Reset: one cycle with rst_in=0 at a clock edge resets everything.
  - Outputs go to 0; state goes to IDLE.
  - Synchroniser, filter and counters clear; filtered level = 0.
  - Reset mid-frame abandons the frame with no pulses.
- Conditioning: 2-FF synchroniser, then filter. The filtered level takes the synchronised value after DEBOUNCE consecutive equal samples that differ from the current level. Fixed latency is 2+DEBOUNCE cycles; measured durations are unaffected.
- Duration counter:
  - Counts cycles since the last filtered edge; saturates at all-ones.
  - Width is $clog2(max(SBD,SSD)+MARGIN+2).
  - "In window N" means N-MARGIN <= cnt <= N+MARGIN, evaluated on the cycle the filtered edge is seen.
- Legal parameters: BSD0+MARGIN < BSD1-MARGIN and RSD+MARGIN < SSD-MARGIN. Behaviour with other values is undefined.
- State encoding: IDLE=0, SYNC_BURST=1, SYNC_SIL=2, BIT_BURST=3, BIT_SIL=4, REP_BURST=5, ERROR=6.
- IDLE:
  - Filtered rising edge -> SYNC_BURST.
- SYNC_BURST:
  - cnt > SBD+MARGIN while high -> ERROR, code 1.
  - Fall with cnt >= SBD-MARGIN -> SYNC_SIL.
  - Fall with a shorter cnt -> IDLE silently (noise rejection).
- SYNC_SIL:
  - Rise in SSD window -> BIT_BURST; clear the shift register and bit count; clear error_out to 0.
  - Rise in RSD window -> REP_BURST.
  - Rise at any other cnt -> ERROR, code 2.
  - cnt > SSD+MARGIN while low -> ERROR, code 2.
- REP_BURST:
  - Fall in BBD window -> pulse repeat_out the next cycle, -> IDLE.
  - Any other fall, or cnt > BBD+MARGIN while high -> ERROR, code 2.
- BIT_BURST:
  - Fall in BBD window -> BIT_SIL.
  - Any other fall, or cnt > BBD+MARGIN while high -> ERROR, code 3.
- BIT_SIL:
  - Rise in BSD0 window -> shift in 0, count++ -> BIT_BURST.
  - Rise in BSD1 window -> shift in 1, count++ -> BIT_BURST.
  - Rise at any other cnt -> ERROR, code 4.
  - A shift attempted when count == MAX_WIDTH -> ERROR, code 5.
  - cnt reaching BSD1+MARGIN+1 while low ends the message (the last burst is the terminator):
    - count >= 1: code_out <= shift register, len_out <= count, pulse new_code_out, -> IDLE.
    - count == 0: -> ERROR, code 6.
- Bit ordering: the first bit received lands at position len-1 and the last at bit 0; bits above len are 0.
- ERROR:
  - On entry, write error_out and pulse new_error_out.
  - Stay until the filtered level has been low for SSD+MARGIN consecutive cycles, then -> IDLE.
  - code_out and len_out are unchanged.
- Pulse exclusivity: new_code_out, repeat_out and new_error_out never assert in the same cycle.
- Retention: code_out and len_out hold until the next good message. error_out holds until the next accepted sync or reset.

Test Plan:
1. Frame 8 bits 0xBA at nominal timing, then terminator burst 500 and silence -> one new_code_out pulse 601+2+DEBOUNCE cycles after the terminator falls; code_out=0xBA, len_out=8, error_out=0.
2. Bit silences of 401 and 600 cycles decode as 1; 150 and 350 decode as 0; a silence of 375 -> error_out=4 with one new_error_out pulse; a following valid frame then decodes.
3. Repeat frame (burst 1000, silence 500, burst 500) -> one repeat_out pulse; code_out unchanged from test 1; new_code_out stays 0.
4. 3-cycle low glitch inside a bit burst -> ignored and the frame decodes correctly; 5-cycle glitch -> error_out=3.
5. 129-bit frame -> error_out=5 with no new_code_out; after 1100+ cycles of silence, a 128-bit 0xAAAA...AAAA frame decodes with len_out=128.
6. rst_in held low for 1 cycle during bit 40 -> all outputs 0 and state_out=0 the next cycle; a subsequent 16-bit frame 0x1234 decodes with len_out=16.
